// File: rtl/snake_ctrl.sv
// Game-sequencing controller for the 8x8 snake display: positions, food, score, game-over.
// Optional macro SNAKE_WRAP_EN: edges wrap instead of causing a wall collision.
module snake_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic [1:0] dir_in,
  input  logic       dir_load,
  output logic [5:0] idx_head,
  output logic [5:0] idx0,
  output logic [5:0] idx1,
  output logic [5:0] idx2,
  output logic [5:0] idx_food,
  output logic       game_over,
  output logic       eat,
  output logic [7:0] score
);

  typedef enum logic [1:0] {IDLE, RUN, PLACE, OVER} state_t;
  typedef enum logic [1:0] {RIGHT = 2'd0, UP = 2'd1, LEFT = 2'd2, DOWN = 2'd3} dir_t;

  state_t     state, state_nxt;
  dir_t       dir, dir_nxt;
  dir_t       pend, pend_nxt;
  logic [5:0] head_nxt, b0_nxt, b1_nxt, b2_nxt, food_nxt;
  logic [5:0] cand, cand_nxt;
  logic [5:0] lfsr, lfsr_nxt;
  logic [7:0] score_nxt;
  logic       game_over_nxt, eat_nxt;
  logic       tick_pend, tick_pend_nxt;

  logic [2:0] hx, hy, nx, ny;
  logic [5:0] nh;
  logic       edge_hit, wall, self_hit, cand_hit, move;

  // Next head cell; 3-bit coordinate arithmetic wraps naturally at the edges.
  always_comb begin
    hx       = idx_head[2:0];
    hy       = idx_head[5:3];
    nx       = hx;
    ny       = hy;
    edge_hit = 1'b0;
    case (pend)
      RIGHT: begin nx = hx + 3'd1; edge_hit = (hx == 3'd7); end
      UP:    begin ny = hy + 3'd1; edge_hit = (hy == 3'd7); end
      LEFT:  begin nx = hx - 3'd1; edge_hit = (hx == 3'd0); end
      DOWN:  begin ny = hy - 3'd1; edge_hit = (hy == 3'd0); end
      default: ;
    endcase
    nh = {ny, nx};
`ifdef SNAKE_WRAP_EN
    wall = 1'b0;
`else
    wall = edge_hit;
`endif
    self_hit = (nh == idx0) || (nh == idx1) || (nh == idx2);
    cand_hit = (cand == idx_head) || (cand == idx0) || (cand == idx1) || (cand == idx2);
  end

  always_comb begin
    state_nxt     = state;
    dir_nxt       = dir;
    pend_nxt      = pend;
    head_nxt      = idx_head;
    b0_nxt        = idx0;
    b1_nxt        = idx1;
    b2_nxt        = idx2;
    food_nxt      = idx_food;
    cand_nxt      = cand;
    score_nxt     = score;
    game_over_nxt = game_over;
    eat_nxt       = 1'b0;
    tick_pend_nxt = tick_pend;
    lfsr_nxt      = {lfsr[4:0], lfsr[5] ^ lfsr[4]};
    move          = 1'b0;

    if (state != OVER && dir_load && dir_in != (dir ^ 2'd2))
      pend_nxt = dir_t'(dir_in);

    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        tick_pend_nxt = 1'b0;
        move          = tick || tick_pend;
        if (move) begin
          dir_nxt = pend;
          if (wall || self_hit) begin
            state_nxt     = OVER;
            game_over_nxt = 1'b1;
          end else begin
            b2_nxt   = idx1;
            b1_nxt   = idx0;
            b0_nxt   = idx_head;
            head_nxt = nh;
            if (nh == idx_food) begin
              eat_nxt   = 1'b1;
              if (score != 8'hFF) score_nxt = score + 8'd1;
              cand_nxt  = lfsr;
              state_nxt = PLACE;
            end
          end
        end
      end
      PLACE: begin
        if (tick) tick_pend_nxt = 1'b1;
        if (cand_hit) begin
          cand_nxt = cand + 6'd1;
        end else begin
          food_nxt  = cand;
          state_nxt = RUN;
        end
      end
      OVER: begin
        if (start) begin
          state_nxt     = RUN;
          dir_nxt       = RIGHT;
          pend_nxt      = RIGHT;
          head_nxt      = 6'd27;
          b0_nxt        = 6'd26;
          b1_nxt        = 6'd25;
          b2_nxt        = 6'd24;
          food_nxt      = 6'd45;
          score_nxt     = '0;
          game_over_nxt = 1'b0;
          tick_pend_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dir       <= RIGHT;
      pend      <= RIGHT;
      idx_head  <= 6'd27;
      idx0      <= 6'd26;
      idx1      <= 6'd25;
      idx2      <= 6'd24;
      idx_food  <= 6'd45;
      cand      <= '0;
      lfsr      <= 6'h2B;
      score     <= '0;
      game_over <= 1'b0;
      eat       <= 1'b0;
      tick_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      dir       <= dir_nxt;
      pend      <= pend_nxt;
      idx_head  <= head_nxt;
      idx0      <= b0_nxt;
      idx1      <= b1_nxt;
      idx2      <= b2_nxt;
      idx_food  <= food_nxt;
      cand      <= cand_nxt;
      lfsr      <= lfsr_nxt;
      score     <= score_nxt;
      game_over <= game_over_nxt;
      eat       <= eat_nxt;
      tick_pend <= tick_pend_nxt;
    end
  end

endmodule
